// File: rtl/rle_control.sv
// rle_control: run-length-encoder control FSM.
// Compares the current word (inA) with the previous word (inB) and
// decides, each clock, whether to increment the run counter or to
// close the run (clear + emit). Counter overflow forces a run close,
// followed by one quiet cycle.
// Build option: CONTROL_REG_OUT_EN
//   defined   -> inc/clr/emit are registered (1-cycle latency)
//   undefined -> inc/clr/emit are combinational decodes (0-cycle latency)
module rle_control (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] inA,
  input  logic [31:0] inB,
  input  logic        overflow,
  output logic        inc,
  output logic        clr,
  output logic        emit
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t state;
  state_t nxt_state;
  logic   match;
  logic   d_inc;
  logic   d_clr;
  logic   d_emit;

  assign match = (inA == inB);

  // Next-state and output decode from the current state and live inputs.
  always_comb begin
    nxt_state = state;
    d_inc     = 1'b0;
    d_clr     = 1'b0;
    d_emit    = 1'b0;
    if (reset) begin
      nxt_state = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          d_clr     = 1'b1;
          nxt_state = RUN;
        end
        RUN: begin
          if (overflow) begin
            d_clr     = 1'b1;
            d_emit    = 1'b1;
            nxt_state = FLUSH;
          end else if (match) begin
            d_inc = 1'b1;
          end else begin
            d_clr  = 1'b1;
            d_emit = 1'b1;
          end
        end
        FLUSH: begin
          nxt_state = RUN;
        end
        default: begin
          nxt_state = IDLE;
        end
      endcase
    end
  end

  // State register; reset folds into the decode so it wins over all inputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nxt_state;
    end
  end

`ifdef CONTROL_REG_OUT_EN
  // Registered outputs: the decision from edge N is visible until edge N+1.
  always_ff @(posedge clock) begin
    if (reset) begin
      inc  <= 1'b0;
      clr  <= 1'b0;
      emit <= 1'b0;
    end else begin
      inc  <= d_inc;
      clr  <= d_clr;
      emit <= d_emit;
    end
  end
`else
  // Combinational outputs straight from the decode.
  always_comb begin
    inc  = d_inc;
    clr  = d_clr;
    emit = d_emit;
  end
`endif

endmodule

// File: tb/tb_rle_control.sv
// Directed testbench for rle_control. Each step applies one input vector
// and checks {inc,clr,emit} against the hand-computed decision for it;
// the sample point follows the output latency of the selected build.
module tb_rle_control;

  logic        clock;
  logic        reset;
  logic [31:0] inA;
  logic [31:0] inB;
  logic        overflow;
  logic        inc;
  logic        clr;
  logic        emit;

  int unsigned checks;
  int unsigned failures;

  rle_control dut (
    .clock    (clock),
    .reset    (reset),
    .inA      (inA),
    .inB      (inB),
    .overflow (overflow),
    .inc      (inc),
    .clr      (clr),
    .emit     (emit)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Count one comparison and report it if it disagrees.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one vector; exp is {inc,clr,emit} for the decision on these inputs.
  task automatic step(input string tag, input logic rst, input logic [31:0] a,
                      input logic [31:0] b, input logic ov, input logic [2:0] exp);
    @(negedge clock);
    reset    = rst;
    inA      = a;
    inB      = b;
    overflow = ov;
`ifdef CONTROL_REG_OUT_EN
    @(posedge clock);
    #1;
`else
    #4;
`endif
    check(tag, {29'd0, inc, clr, emit}, {29'd0, exp});
    check({tag, "_excl"}, {31'd0, inc & clr}, 32'd0);
`ifndef CONTROL_REG_OUT_EN
    @(posedge clock);
`endif
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    inA      = '0;
    inB      = '0;
    overflow = 1'b0;

    // reset held two cycles, then IDLE clear, then counting
    step("rst0",     1'b1, 32'h0,        32'h0,        1'b0, 3'b000);
    step("rst1",     1'b1, 32'h0,        32'h0,        1'b0, 3'b000);
    step("idle_clr", 1'b0, 32'h0,        32'h0,        1'b0, 3'b010);
    step("inc0",     1'b0, 32'h0,        32'h0,        1'b0, 3'b100);
    step("inc1",     1'b0, 32'h0,        32'h0,        1'b0, 3'b100);
    // persistent mismatch, then rematch
    step("mis0",     1'b0, 32'hFFFFFFFF, 32'h00000000, 1'b0, 3'b011);
    step("mis1",     1'b0, 32'hFFFFFFFF, 32'h00000000, 1'b0, 3'b011);
    step("rematch",  1'b0, 32'hAAAAAAAA, 32'hAAAAAAAA, 1'b0, 3'b100);
    step("remis",    1'b0, 32'hAAAAAAAA, 32'h00000000, 1'b0, 3'b011);
    // overflow held high on matching data: flush, quiet, flush, ...
    step("ovf0",     1'b0, 32'hA0A0A0A0, 32'hA0A0A0A0, 1'b1, 3'b011);
    step("flush0",   1'b0, 32'hA0A0A0A0, 32'hA0A0A0A0, 1'b1, 3'b000);
    step("ovf1",     1'b0, 32'hA0A0A0A0, 32'hA0A0A0A0, 1'b1, 3'b011);
    step("flush1",   1'b0, 32'hA0A0A0A0, 32'hA0A0A0A0, 1'b1, 3'b000);
    step("ovf2",     1'b0, 32'hA0A0A0A0, 32'hA0A0A0A0, 1'b1, 3'b011);
    // reset while in FLUSH
    step("rst_fl",   1'b1, 32'hA0A0A0A0, 32'hA0A0A0A0, 1'b0, 3'b000);
    step("idle_clr2",1'b0, 32'h5,        32'h5,        1'b0, 3'b010);
    step("inc2",     1'b0, 32'h5,        32'h5,        1'b0, 3'b100);
    // reset while counting
    step("rst_inc",  1'b1, 32'h5,        32'h5,        1'b0, 3'b000);
    step("idle_clr3",1'b0, 32'h5,        32'h5,        1'b0, 3'b010);
    step("inc3",     1'b0, 32'h5,        32'h5,        1'b0, 3'b100);
    // single-bit differences at both ends of the word
    step("msb_diff", 1'b0, 32'h80000000, 32'h00000000, 1'b0, 3'b011);
    step("lsb_diff", 1'b0, 32'h00000001, 32'h00000000, 1'b0, 3'b011);
    step("inc4",     1'b0, 32'h12345678, 32'h12345678, 1'b0, 3'b100);
    // overflow outranks a mismatch; overflow ignored in FLUSH
    step("ovf_mis",  1'b0, 32'h1,        32'h2,        1'b1, 3'b011);
    step("flush2",   1'b0, 32'h1,        32'h2,        1'b1, 3'b000);
    step("back_run", 1'b0, 32'h7,        32'h7,        1'b0, 3'b100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
